game_timer_arbiter: RTL and testbench

GAME_TIMER_ARBITER -- requirements
Module: game_timer_arbiter

---
 rtl/game_timer_arbiter.sv | 157 +++++++++++++++
 tb/tb_game_timer_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/game_timer_arbiter.sv
// game_timer_arbiter
// Shares one external game_timer between N_REQ requesters. A requester is
// granted the timer, its delay is launched, and a one-cycle done pulse is
// returned on its bit when the timer stops running.
// Build option: define GAME_TIMER_ARB_FIXED_PRIO_EN to replace round-robin
// arbitration with fixed priority (lowest index wins, no pointer state).
module game_timer_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] req_value,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic                   timer_start,
  output logic [WIDTH-1:0]       timer_value,
  input  logic                   timer_running
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    ARM    = 3'd2,
    WAIT   = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t state, state_next;

  logic             win_found;
  logic [N_REQ-1:0] win_oh;
  logic [WIDTH-1:0] win_value;

`ifdef GAME_TIMER_ARB_FIXED_PRIO_EN

  // Fixed priority: scan from the top so the lowest asserted index is the last writer
  always_comb begin
    win_found = 1'b0;
    win_oh    = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_found = 1'b1;
        win_oh    = '0;
        win_oh[i] = 1'b1;
      end
    end
  end

`else

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] ptr_next;
  logic [IDX_W-1:0] win_idx;
  logic             found_hi;
  logic [N_REQ-1:0] oh_hi;
  logic [N_REQ-1:0] oh_lo;
  logic [IDX_W-1:0] idx_hi;
  logic [IDX_W-1:0] idx_lo;

  // Round-robin: lowest asserted index at or above the pointer wins, else wrap to the lowest overall
  always_comb begin
    win_found = 1'b0;
    found_hi  = 1'b0;
    oh_hi     = '0;
    oh_lo     = '0;
    idx_hi    = '0;
    idx_lo    = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_found = 1'b1;
        oh_lo     = '0;
        oh_lo[i]  = 1'b1;
        idx_lo    = IDX_W'(i);
        if (i >= int'(ptr)) begin
          found_hi = 1'b1;
          oh_hi    = '0;
          oh_hi[i] = 1'b1;
          idx_hi   = IDX_W'(i);
        end
      end
    end
    win_oh  = found_hi ? oh_hi  : oh_lo;
    win_idx = found_hi ? idx_hi : idx_lo;
    if (win_idx == IDX_W'(N_REQ - 1)) begin
      ptr_next = '0;
    end else begin
      ptr_next = win_idx + 1'b1;
    end
  end

  // Priority pointer advances past each winner when a grant is issued
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (state == IDLE && win_found) begin
      ptr <= ptr_next;
    end
  end

`endif

  // Select the winner's delay slice
  always_comb begin
    win_value = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_oh[i]) begin
        win_value = req_value[i*WIDTH +: WIDTH];
      end
    end
  end

  // State, grant and latched delay; grant/value are frozen from LAUNCH until DONE retires
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      grant       <= '0;
      timer_value <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && win_found) begin
        grant       <= win_oh;
        timer_value <= win_value;
      end else if (state == DONE) begin
        grant <= '0;
      end
    end
  end

  // Next-state logic; ARM blindly covers the timer's running rise
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (win_found) state_next = LAUNCH;
      LAUNCH:  state_next = ARM;
      ARM:     state_next = WAIT;
      WAIT:    if (!timer_running) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Moore outputs decoded from the state
  always_comb begin
    busy        = 1'b0;
    timer_start = 1'b0;
    done        = '0;
    if (state != IDLE)  busy        = 1'b1;
    if (state == LAUNCH) timer_start = 1'b1;
    if (state == DONE)  done        = grant;
  end

endmodule

// File: tb/tb_game_timer_arbiter.sv
// Directed bench for game_timer_arbiter with a behavioural model of the
// shared game_timer (running rises two edges after start and stays high
// for value+1 cycles).
module tb_game_timer_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_value;
  logic [N-1:0]   grant;
  logic [N-1:0]   done;
  logic           busy;
  logic           timer_start;
  logic [W-1:0]   timer_value;
  logic           timer_running;

  int tests;
  int fails;
  int cyc;
  int done_cnt;

  game_timer_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk           (clk),
    .reset         (rst_n),
    .req           (req),
    .req_value     (req_value),
    .grant         (grant),
    .done          (done),
    .busy          (busy),
    .timer_start   (timer_start),
    .timer_value   (timer_value),
    .timer_running (timer_running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done != '0) done_cnt = done_cnt + 1;

  // Shared timer model
  logic        start_d;
  logic [W-1:0] cnt_m;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_d       <= 1'b0;
      timer_running <= 1'b0;
      cnt_m         <= '0;
    end else begin
      start_d <= timer_start;
      if (start_d) begin
        timer_running <= 1'b1;
        cnt_m         <= timer_value;
      end else if (timer_running) begin
        if (cnt_m == 0) timer_running <= 1'b0;
        else            cnt_m <= cnt_m - 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_start(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (timer_start !== 1'b1 && n < 100);
    if (timer_start !== 1'b1) chk({tag, "_start_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic wait_done(input string tag, input int t0, input int exp_lat,
                           input logic [N-1:0] exp_done);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done === '0 && n < 100);
    if (done === '0) begin
      chk({tag, "_done_timeout"}, 64'd0, 64'd1);
    end else begin
      chk({tag, "_lat"}, 64'(cyc - t0), 64'(exp_lat));
      chk({tag, "_done"}, 64'(done), 64'(exp_done));
    end
  endtask

  logic [N-1:0] exp_g;
  int t0;
  int dc;

  initial begin
    tests = 0; fails = 0; cyc = 0; done_cnt = 0;
    rst_n = 1'b0;
    req = '0;
    req_value = '0;
    repeat (2) @(negedge clk);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_done",  64'(done), 64'd0);
    chk("rst_busy",  64'(busy), 64'd0);
    chk("rst_start", 64'(timer_start), 64'd0);
    chk("rst_value", 64'(timer_value), 64'd0);
    rst_n = 1'b1;

    // Single request, value 5; value change after grant must not leak in
    @(negedge clk);
    req = 4'b0010;
    req_value[1*W +: W] = 32'd5;
    @(negedge clk);
    chk("t1_grant", 64'(grant), 64'b0010);
    chk("t1_start", 64'(timer_start), 64'd1);
    chk("t1_busy",  64'(busy), 64'd1);
    t0 = cyc;
    req = '0;
    req_value[1*W +: W] = 32'd99;
    wait_done("t1", t0, 9, 4'b0010);
    chk("t1_value_held", 64'(timer_value), 64'd5);
    @(negedge clk);
    chk("t1_busy_after", 64'(busy), 64'd0);
    chk("t1_grant_after", 64'(grant), 64'd0);
    chk("t1_done_once", 64'(done), 64'd0);

    // Zero delay on requester 3
    req = 4'b1000;
    req_value[3*W +: W] = 32'd0;
    @(negedge clk);
    chk("t2_grant", 64'(grant), 64'b1000);
    chk("t2_start", 64'(timer_start), 64'd1);
    t0 = cyc;
    req = '0;
    wait_done("t2", t0, 4, 4'b1000);
    @(negedge clk);

    // Drop req[2] two cycles after grant, value 10
    req = 4'b0100;
    req_value[2*W +: W] = 32'd10;
    @(negedge clk);
    chk("t3_grant", 64'(grant), 64'b0100);
    t0 = cyc;
    repeat (2) @(negedge clk);
    req = '0;
    chk("t3_grant_hold", 64'(grant), 64'b0100);
    wait_done("t3", t0, 14, 4'b0100);
    @(negedge clk);

    // All four requesting, value 2 each, from a fresh pointer
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'b1111;
    for (int i = 0; i < N; i++) req_value[i*W +: W] = 32'd2;
    for (int g = 0; g < 5; g++) begin
`ifdef GAME_TIMER_ARB_FIXED_PRIO_EN
      exp_g = 4'b0001;
`else
      exp_g = 4'(1 << (g % N));
`endif
      wait_start($sformatf("rr%0d", g));
      chk($sformatf("rr%0d_grant", g), 64'(grant), 64'(exp_g));
      t0 = cyc;
      wait_done($sformatf("rr%0d", g), t0, 6, exp_g);
    end
    req = '0;
    repeat (2) @(negedge clk);

    // Reset during WAIT with owner 1
    req = 4'b0010;
    req_value[1*W +: W] = 32'd20;
    @(negedge clk);
    chk("t5_grant", 64'(grant), 64'b0010);
    req = '0;
    repeat (4) @(negedge clk);
    chk("t5_busy_wait", 64'(busy), 64'd1);
    dc = done_cnt;
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_grant", 64'(grant), 64'd0);
    chk("t5_async_busy",  64'(busy), 64'd0);
    chk("t5_async_start", 64'(timer_start), 64'd0);
    chk("t5_async_value", 64'(timer_value), 64'd0);
    chk("t5_async_done",  64'(done), 64'd0);
    repeat (3) @(negedge clk);
    chk("t5_no_done", 64'(done_cnt), 64'(dc));
    req = 4'b1111;
    for (int i = 0; i < N; i++) req_value[i*W +: W] = 32'd1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_first_grant", 64'(grant), 64'b0001);
    chk("t5_first_start", 64'(timer_start), 64'd1);
    t0 = cyc;
    req = '0;
    wait_done("t5", t0, 5, 4'b0001);
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
